mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 166 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns decoded memory ops into single-outstanding
// valid/ready bus transactions, with byte-lane steering and load extension.
package mem_access_pkg;
  typedef enum logic [3:0] {
    MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_t;
endpackage

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  mem_op_t         mem_ctrl,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            misaligned_o,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_rsp_valid,
  input  logic [XLEN-1:0] bus_rsp_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state_q;
  mem_op_t         op_q;
  logic [1:0]      off_q;
  logic            done_q;
  logic            req_valid_q;
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [3:0]      be_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;

  logic            is_byte, is_half, is_word, is_store;
  logic            mis_raw;
  logic            accept;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d;
  logic [XLEN-1:0] rdata_d;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic            op_q_store;

  // Decode size/direction of the op currently presented by the pipeline.
  always_comb begin
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    is_store = 1'b0;
    case (mem_ctrl)
      MEM_LB, MEM_LBU: is_byte = 1'b1;
      MEM_LH, MEM_LHU: is_half = 1'b1;
      MEM_LW:          is_word = 1'b1;
      MEM_SB: begin is_byte = 1'b1; is_store = 1'b1; end
      MEM_SH: begin is_half = 1'b1; is_store = 1'b1; end
      MEM_SW: begin is_word = 1'b1; is_store = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    mis_raw = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
    accept  = (state_q == IDLE) & req_valid & (mem_ctrl != MEM_NOP)
              & ~mis_raw & ~done_q;
  end

  assign misaligned_o = (state_q == IDLE) & req_valid & ~done_q & mis_raw;
  assign stall_o      = accept | (state_q != IDLE);

  // Byte enables and lane-replicated store data for the presented op.
  always_comb begin
    be_d    = '0;
    wdata_d = '0;
    if (is_byte) begin
      be_d = 4'b0001 << addr[1:0];
      if (is_store) wdata_d = {4{wdata[7:0]}};
    end else if (is_half) begin
      be_d = addr[1] ? 4'b1100 : 4'b0011;
      if (is_store) wdata_d = {2{wdata[15:0]}};
    end else if (is_word) begin
      be_d = 4'b1111;
      if (is_store) wdata_d = wdata;
    end
  end

  // Extract and extend the load result using the latched op and offset.
  always_comb begin
    byte_sel   = bus_rsp_data[{off_q, 3'b000} +: 8];
    half_sel   = off_q[1] ? bus_rsp_data[31:16] : bus_rsp_data[15:0];
    op_q_store = (op_q == MEM_SB) | (op_q == MEM_SH) | (op_q == MEM_SW);
    case (op_q)
      MEM_LB:  rdata_d = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: rdata_d = {24'h000000, byte_sel};
      MEM_LH:  rdata_d = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: rdata_d = {16'h0000, half_sel};
      default: rdata_d = bus_rsp_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= MEM_NOP;
      off_q       <= '0;
      done_q      <= 1'b0;
      req_valid_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= REQ;
            op_q        <= mem_ctrl;
            off_q       <= addr[1:0];
            req_valid_q <= 1'b1;
            we_q        <= is_store;
            addr_q      <= {addr[XLEN-1:2], 2'b00};
            be_q        <= be_d;
            wdata_q     <= wdata_d;
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            state_q     <= WAIT;
            req_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (bus_rsp_valid) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            if (!op_q_store) rdata_q <= rdata_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done_o        = done_q;
  assign rdata_o       = rdata_q;
  assign bus_req_valid = req_valid_q;
  assign bus_we        = we_q;
  assign bus_addr      = addr_q;
  assign bus_be        = be_q;
  assign bus_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: aligned loads/stores, backpressure,
// misalignment, NOP, and asynchronous reset during an outstanding access.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  mem_op_t     mem_ctrl;
  logic [31:0] addr, wdata;
  logic        stall_o, done_o, misaligned_o;
  logic [31:0] rdata_o;
  logic        bus_req_valid, bus_req_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rsp_data;
  logic [3:0]  bus_be;
  logic        bus_rsp_valid;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .mem_ctrl(mem_ctrl),
    .addr(addr), .wdata(wdata), .stall_o(stall_o), .done_o(done_o),
    .rdata_o(rdata_o), .misaligned_o(misaligned_o),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid),
    .bus_rsp_data(bus_rsp_data)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One complete access; ready is held low for nready REQ cycles first.
  task automatic do_access(input string name, input mem_op_t op,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int unsigned nready, input logic [31:0] rsp,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic exp_we, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_rdata);
    req_valid     = 1'b1;
    mem_ctrl      = op;
    addr          = a;
    wdata         = wd;
    bus_req_ready = (nready == 0);
    bus_rsp_valid = 1'b0;
    settle();
    check({name, "_acc_stall"}, 32'(stall_o), 32'd1);
    check({name, "_acc_mis"}, 32'(misaligned_o), 32'd0);
    step();
    for (int i = 0; i <= int'(nready); i++) begin
      check({name, "_req_valid"}, 32'(bus_req_valid), 32'd1);
      check({name, "_req_addr"}, bus_addr, exp_addr);
      check({name, "_req_be"}, 32'(bus_be), 32'(exp_be));
      check({name, "_req_we"}, 32'(bus_we), 32'(exp_we));
      check({name, "_req_wdata"}, bus_wdata, exp_wdata);
      check({name, "_req_stall"}, 32'(stall_o), 32'd1);
      if (i == int'(nready)) bus_req_ready = 1'b1;
      step();
    end
    bus_req_ready = 1'b0;
    check({name, "_wait_valid"}, 32'(bus_req_valid), 32'd0);
    check({name, "_wait_stall"}, 32'(stall_o), 32'd1);
    check({name, "_wait_done"}, 32'(done_o), 32'd0);
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = rsp;
    step();
    bus_rsp_valid = 1'b0;
    check({name, "_done"}, 32'(done_o), 32'd1);
    check({name, "_done_stall"}, 32'(stall_o), 32'd0);
    check({name, "_done_rdata"}, rdata_o, exp_rdata);
    req_valid = 1'b0;
    mem_ctrl  = MEM_NOP;
    step();
    check({name, "_done_pulse"}, 32'(done_o), 32'd0);
    check({name, "_no_reaccept"}, 32'(bus_req_valid), 32'd0);
  endtask

  task automatic do_misaligned(input string name, input mem_op_t op, input logic [31:0] a);
    req_valid = 1'b1;
    mem_ctrl  = op;
    addr      = a;
    wdata     = 32'hFFFF_FFFF;
    bus_req_ready = 1'b1;
    settle();
    check({name, "_mis"}, 32'(misaligned_o), 32'd1);
    check({name, "_stall"}, 32'(stall_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check({name, "_no_bus"}, 32'(bus_req_valid), 32'd0);
      check({name, "_mis_hold"}, 32'(misaligned_o), 32'd1);
    end
    req_valid = 1'b0;
    mem_ctrl  = MEM_NOP;
    bus_req_ready = 1'b0;
    settle();
    check({name, "_mis_clear"}, 32'(misaligned_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    mem_ctrl = MEM_NOP;
    addr = '0;
    wdata = '0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_data = '0;
    step();
    step();
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_valid", 32'(bus_req_valid), 32'd0);
    check("rst_we", 32'(bus_we), 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_be", 32'(bus_be), 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    rst_n = 1'b1;
    step();

    do_access("lw",  MEM_LW,  32'h0000_1004, 32'h0, 0, 32'hDEAD_BEEF,
              32'h0000_1004, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF);
    do_access("lb",  MEM_LB,  32'h0000_1003, 32'h0, 0, 32'h80FF_0000,
              32'h0000_1000, 4'b1000, 1'b0, 32'h0, 32'hFFFF_FF80);
    do_access("lbu", MEM_LBU, 32'h0000_1003, 32'h0, 0, 32'h80FF_0000,
              32'h0000_1000, 4'b1000, 1'b0, 32'h0, 32'h0000_0080);
    do_access("lh",  MEM_LH,  32'h0000_1000, 32'h0, 1, 32'h1234_8001,
              32'h0000_1000, 4'b0011, 1'b0, 32'h0, 32'hFFFF_8001);
    do_access("lb0", MEM_LB,  32'h0000_1001, 32'h0, 0, 32'h0000_7F00,
              32'h0000_1000, 4'b0010, 1'b0, 32'h0, 32'h0000_007F);
    do_access("lhu", MEM_LHU, 32'h0000_1002, 32'h0, 0, 32'h80FF_0000,
              32'h0000_1000, 4'b1100, 1'b0, 32'h0, 32'h0000_80FF);
    do_access("sh",  MEM_SH,  32'h0000_2002, 32'h1234_5678, 0, 32'hCAFE_F00D,
              32'h0000_2000, 4'b1100, 1'b1, 32'h5678_5678, 32'h0000_80FF);
    do_access("sb",  MEM_SB,  32'h0000_3001, 32'h0000_00AB, 4, 32'hCAFE_F00D,
              32'h0000_3000, 4'b0010, 1'b1, 32'hABAB_ABAB, 32'h0000_80FF);
    do_access("sw",  MEM_SW,  32'h0000_4000, 32'hA5A5_0F0F, 0, 32'h1111_1111,
              32'h0000_4000, 4'b1111, 1'b1, 32'hA5A5_0F0F, 32'h0000_80FF);

    do_misaligned("mis_lw", MEM_LW, 32'h0000_1002);
    do_misaligned("mis_sh", MEM_SH, 32'h0000_1001);

    req_valid = 1'b1;
    mem_ctrl  = MEM_NOP;
    addr      = 32'h0000_1003;
    settle();
    check("nop_stall", 32'(stall_o), 32'd0);
    check("nop_mis", 32'(misaligned_o), 32'd0);
    step();
    check("nop_no_bus", 32'(bus_req_valid), 32'd0);
    req_valid = 1'b0;

    // Reset while the load is waiting for its response.
    req_valid = 1'b1;
    mem_ctrl  = MEM_LW;
    addr      = 32'h0000_5008;
    bus_req_ready = 1'b1;
    step();
    step();
    bus_req_ready = 1'b0;
    req_valid = 1'b0;
    mem_ctrl  = MEM_NOP;
    check("rw_in_wait", 32'(stall_o), 32'd1);
    rst_n = 1'b0;
    settle();
    check("rw_stall", 32'(stall_o), 32'd0);
    check("rw_addr", bus_addr, 32'd0);
    check("rw_be", 32'(bus_be), 32'd0);
    check("rw_rdata", rdata_o, 32'd0);
    #3;
    rst_n = 1'b1;
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = 32'h5555_AAAA;
    step();
    bus_rsp_valid = 1'b0;
    check("rw_late_done", 32'(done_o), 32'd0);
    check("rw_late_rdata", rdata_o, 32'd0);
    check("rw_late_valid", 32'(bus_req_valid), 32'd0);
    check("rw_late_stall", 32'(stall_o), 32'd0);
    step();
    check("rw_late_done2", 32'(done_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
